colour_action_sequencer: RTL
============================

// Module: colour_action_sequencer
// PURPOSE
//  Downstream consumer of the colour detector's 2-bit cd_out code (00 red, 01 green, 10 blue, 11 invalid).
//  Resynchronises cd_out and its 200 ms strobe, debounces colour over consecutive samples, then runs an
//  actuation sequence (handshake with motion controller, timed pump/valve pulse, hold-off) per colour.
//  Sits between color detection and the pump/valve drivers and locomotion FSM.
// PARAMETERS
//  STABLE_CNT    3       identical valid samples required to accept a colour (1..15)
//  ACT_TICKS     50000   scaled_clock cycles the actuator output stays on (1..2^24-1)
//  HOLDOFF_TICKS 25000   cycles in COOLDOWN after actuation (0..2^24-1)
//  ACK_TIMEOUT   100000  cycles to wait for act_ack before abort (1..2^24-1)
// PORTS
//  scaled_clock       in   1   system clock
//  rst_n              in   1   synchronous reset, active-low
//  scaled_clock_200ms in   1   detector sample clock (async); detector updates cd_out on its falling edge
//  cd_out             in   2   colour code from detector (async)
//  act_ack            in   1   motion controller: robot halted, actuation permitted (level)
//  act_req            out  1   request halt for actuation
//  act_colour         out  2   accepted colour being serviced (valid while act_req or busy)
//  busy               out  1   FSM not in IDLE
//  pump_water         out  1   water valve on (green)
//  pump_spray         out  1   spray valve on (red)
//  stop_req           out  1   one-cycle pulse: blue marker reached
//  ack_timeout        out  1   one-cycle pulse: act_ack not seen within ACK_TIMEOUT
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): all outputs 0, state IDLE, all counters 0, sync flops 0, last_colour=11.
//  Input sync: 2-flop synchronisers on scaled_clock_200ms and both cd_out bits. Sample strobe = falling
//   edge of synchronised 200ms clock, delayed one extra cycle; cd_out sampled on that strobe (ensures
//   detector update has settled through sync). Latency edge->sample: 4 cycles.
//  Debounce (runs in all states): on strobe, if sample==11 -> stab_cnt=0; elif sample==last_colour ->
//   stab_cnt=min(stab_cnt+1,15); else stab_cnt=1, last_colour=sample. accept=1 (one cycle) when stab_cnt
//   reaches exactly STABLE_CNT on a strobe; no re-accept until colour changes or 11 intervenes.
//  FSM states / transitions:
//   IDLE: accept -> latch act_colour; blue -> stop_req pulse, stay IDLE; red/green -> REQ.
//   REQ: act_req=1, timer counts. act_ack=1 -> ACTIVE, timer=0. timer==ACK_TIMEOUT-1 -> ack_timeout
//        pulse, act_req drops, IDLE.
//   ACTIVE: pump_spray (red) or pump_water (green) =1 for exactly ACT_TICKS cycles; act_req held 1.
//        act_ack dropping early -> valve off next cycle, go COOLDOWN (abort).
//   COOLDOWN: act_req=0, valves 0, HOLDOFF_TICKS cycles then IDLE (HOLDOFF_TICKS=0 -> IDLE next cycle).
//  accept while busy is discarded (not queued). accept and state-exit same cycle: accept discarded.
//  Pump outputs are registered; never both 1. Timer is 24-bit, cleared on every state entry.
//  rst_n low mid-ACTIVE: valves drop on that same posedge.
// CONFIGURATION
//  COLOUR_STATS_EN defined: adds outputs cnt_red, cnt_green, cnt_blue (16 bits each), incremented on
//   each accept of that colour (including accepts discarded while busy), saturating at 65535, reset 0.
//  Undefined: those ports and counters do not exist; all other behaviour identical.
// TESTING (STABLE_CNT=3, ACT_TICKS=10, HOLDOFF_TICKS=5, ACK_TIMEOUT=20)
//  1 cd_out=01 for 3 strobes, act_ack=1 two cycles after act_req -> pump_water high exactly 10 cycles,
//    busy low 5 cycles after pump drops.
//  2 cd_out=00,00,11,00,00 -> no act_req; a third 00 strobe -> act_req with act_colour=00.
//  3 cd_out=10 for 3 strobes -> single stop_req pulse, act_req stays 0; 4th 10 strobe -> no new pulse.
//  4 red accepted, act_ack held 0 -> ack_timeout pulse on 20th REQ cycle, act_req 0, back to IDLE.
//  5 ACTIVE red, act_ack dropped after 4 cycles -> pump_spray 0 next cycle, COOLDOWN 5 cycles.
//  6 rst_n=0 for 1 cycle mid-ACTIVE -> all outputs 0 that posedge; with COLOUR_STATS_EN counters read 0.

Source files
------------

// File: rtl/colour_action_sequencer.sv
// colour_action_sequencer
// Consumes the colour detector's 2-bit code (00 red, 01 green, 10 blue, 11 invalid).
// It resynchronises the code and its sample clock, debounces the colour over consecutive samples,
// and services each accepted colour:
//   - blue raises a stop pulse;
//   - red or green runs a handshake, a timed valve pulse and a hold-off.
// Optional feature macro: COLOUR_STATS_EN adds saturating per-colour accept counters.
// Handshake: act_req rises when a red/green colour is accepted and stays high through REQ and
// ACTIVE; act_ack is a level from the motion controller. It is sampled on every clock edge, and
// only its high level permits and sustains actuation.
module colour_action_sequencer #(
  parameter int STABLE_CNT    = 3,
  parameter int ACT_TICKS     = 50000,
  parameter int HOLDOFF_TICKS = 25000,
  parameter int ACK_TIMEOUT   = 100000
) (
  input  logic        scaled_clock,
  input  logic        rst_n,
  input  logic        scaled_clock_200ms,
  input  logic [1:0]  cd_out,
  input  logic        act_ack,
  output logic        act_req,
  output logic [1:0]  act_colour,
  output logic        busy,
  output logic        pump_water,
  output logic        pump_spray,
  output logic        stop_req,
  output logic        ack_timeout,
  output logic [1:0]  dbg_state_o
`ifdef COLOUR_STATS_EN
  ,
  output logic [15:0] cnt_red,
  output logic [15:0] cnt_green,
  output logic [15:0] cnt_blue
`endif
);

  localparam logic [3:0]  STABLE_C = 4'(STABLE_CNT);
  localparam logic [23:0] ACK_LAST = 24'(ACK_TIMEOUT - 1);
  localparam logic [23:0] ACT_LAST = 24'(ACT_TICKS - 1);
  // A zero hold-off still spends one cycle in COOLDOWN before returning to IDLE.
  localparam logic [23:0] HOLD_LAST = 24'((HOLDOFF_TICKS == 0) ? 0 : HOLDOFF_TICKS - 1);

  localparam logic [1:0] C_RED     = 2'b00;
  localparam logic [1:0] C_GREEN   = 2'b01;
  localparam logic [1:0] C_BLUE    = 2'b10;
  localparam logic [1:0] C_INVALID = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_REQ      = 2'd1,
    S_ACTIVE   = 2'd2,
    S_COOLDOWN = 2'd3
  } state_e;

  // Synchroniser and strobe registers
  logic       s200_meta_q, s200_sync_q, s200_prev_q, strobe_q;
  logic [1:0] cd_meta_q, cd_sync_q;

  // Debounce registers
  logic [3:0] stab_q, stab_d;
  logic [1:0] last_q, last_d;
  logic       accept;

  // FSM registers
  state_e      state_q;
  logic [23:0] timer_q;
  logic        act_req_q, busy_q, pump_water_q, pump_spray_q, stop_req_q, ack_timeout_q;
  logic [1:0]  act_colour_q;

  // Two-flop synchronisers. The strobe is the synchronised falling edge delayed one more cycle, so
  // the code the detector changed on that edge has already crossed its own synchroniser.
  always_ff @(posedge scaled_clock) begin
    if (!rst_n) begin
      s200_meta_q <= 1'b0;
      s200_sync_q <= 1'b0;
      s200_prev_q <= 1'b0;
      strobe_q    <= 1'b0;
      cd_meta_q   <= 2'b00;
      cd_sync_q   <= 2'b00;
    end else begin
      s200_meta_q <= scaled_clock_200ms;
      s200_sync_q <= s200_meta_q;
      s200_prev_q <= s200_sync_q;
      strobe_q    <= s200_prev_q & ~s200_sync_q;
      cd_meta_q   <= cd_out;
      cd_sync_q   <= cd_meta_q;
    end
  end

  // Debounce next state: count identical valid samples; accept exactly once per run reaching STABLE_CNT.
  always_comb begin
    stab_d = stab_q;
    last_d = last_q;
    accept = 1'b0;
    if (strobe_q) begin
      if (cd_sync_q == C_INVALID) begin
        stab_d = 4'd0;
      end else if (cd_sync_q == last_q) begin
        stab_d = (stab_q == 4'hF) ? 4'hF : stab_q + 4'd1;
      end else begin
        stab_d = 4'd1;
        last_d = cd_sync_q;
      end
      // A saturated count that stays equal to STABLE_C must not re-accept the same colour.
      accept = (cd_sync_q != C_INVALID) && (stab_d == STABLE_C) &&
               ((stab_q != STABLE_C) || (cd_sync_q != last_q));
    end
  end

  // Debounce state registers
  always_ff @(posedge scaled_clock) begin
    if (!rst_n) begin
      stab_q <= 4'd0;
      last_q <= C_INVALID;
    end else begin
      stab_q <= stab_d;
      last_q <= last_d;
    end
  end

  // Actuation FSM with registered outputs. Any accept outside IDLE is dropped.
  always_ff @(posedge scaled_clock) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      timer_q       <= 24'd0;
      act_req_q     <= 1'b0;
      busy_q        <= 1'b0;
      pump_water_q  <= 1'b0;
      pump_spray_q  <= 1'b0;
      stop_req_q    <= 1'b0;
      ack_timeout_q <= 1'b0;
      act_colour_q  <= 2'b00;
    end else begin
      stop_req_q    <= 1'b0;
      ack_timeout_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            act_colour_q <= cd_sync_q;
            if (cd_sync_q == C_BLUE) begin
              stop_req_q <= 1'b1;
            end else begin
              state_q   <= S_REQ;
              timer_q   <= 24'd0;
              act_req_q <= 1'b1;
              busy_q    <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (act_ack) begin
            state_q      <= S_ACTIVE;
            timer_q      <= 24'd0;
            pump_spray_q <= (act_colour_q == C_RED);
            pump_water_q <= (act_colour_q == C_GREEN);
          end else if (timer_q == ACK_LAST) begin
            state_q       <= S_IDLE;
            timer_q       <= 24'd0;
            act_req_q     <= 1'b0;
            busy_q        <= 1'b0;
            ack_timeout_q <= 1'b1;
          end else begin
            timer_q <= timer_q + 24'd1;
          end
        end
        S_ACTIVE: begin
          // Losing act_ack aborts the pulse exactly like reaching its normal end.
          if (!act_ack || (timer_q == ACT_LAST)) begin
            state_q      <= S_COOLDOWN;
            timer_q      <= 24'd0;
            act_req_q    <= 1'b0;
            pump_spray_q <= 1'b0;
            pump_water_q <= 1'b0;
          end else begin
            timer_q <= timer_q + 24'd1;
          end
        end
        S_COOLDOWN: begin
          if (timer_q == HOLD_LAST) begin
            state_q <= S_IDLE;
            timer_q <= 24'd0;
            busy_q  <= 1'b0;
          end else begin
            timer_q <= timer_q + 24'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          timer_q <= 24'd0;
        end
      endcase
    end
  end

  assign act_req     = act_req_q;
  assign act_colour  = act_colour_q;
  assign busy        = busy_q;
  assign pump_water  = pump_water_q;
  assign pump_spray  = pump_spray_q;
  assign stop_req    = stop_req_q;
  assign ack_timeout = ack_timeout_q;
  assign dbg_state_o = state_q;

`ifdef COLOUR_STATS_EN
  logic [15:0] cnt_red_q, cnt_green_q, cnt_blue_q;

  // Per-colour accept counters; they count every accept, including ones dropped while busy.
  always_ff @(posedge scaled_clock) begin
    if (!rst_n) begin
      cnt_red_q   <= 16'd0;
      cnt_green_q <= 16'd0;
      cnt_blue_q  <= 16'd0;
    end else if (accept) begin
      if ((cd_sync_q == C_RED) && (cnt_red_q != 16'hFFFF))     cnt_red_q   <= cnt_red_q + 16'd1;
      if ((cd_sync_q == C_GREEN) && (cnt_green_q != 16'hFFFF)) cnt_green_q <= cnt_green_q + 16'd1;
      if ((cd_sync_q == C_BLUE) && (cnt_blue_q != 16'hFFFF))   cnt_blue_q  <= cnt_blue_q + 16'd1;
    end
  end

  assign cnt_red   = cnt_red_q;
  assign cnt_green = cnt_green_q;
  assign cnt_blue  = cnt_blue_q;
`endif

endmodule
